// File: rtl/larpix_piso_packet_rx.sv
// Receive-side UART deserializer for one LArPix PISO link.
// Recovers start/data/stop frames, flags odd-parity failures and framing
// errors, and buffers packets in a small first-word-fallthrough FIFO.
module larpix_piso_packet_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int WIDTH        = 64,
  parameter int OUT_DEPTH    = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             piso_in,
  output logic [WIDTH-1:0] packet_out,
  output logic             parity_error,
  output logic             packet_valid,
  input  logic             packet_ready,
  output logic             frame_error,
  output logic [CNT_W-1:0] drop_count,
  output logic             rx_busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(WIDTH);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Synchronizer and edge-detect history
  logic s_meta;
  logic s_sync;
  logic s_prev;

  // Receiver state
  rx_state_t        state;
  rx_state_t        state_next;
  logic [CLK_W-1:0] clk_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_reg;

  // Control strobes from the next-state logic
  logic cnt_clr;
  logic shift_en;
  logic bit_clr;
  logic push_req;
  logic frame_err_set;

  // Output FIFO storage and bookkeeping
  logic [WIDTH:0]     mem [OUT_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [OCC_W-1:0]   occ;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic [WIDTH:0]     push_word;
  logic [WIDTH:0]     head_word;

  // Two-flop synchronizer on the serial line plus one more stage of history
  // so IDLE can spot a falling edge; everything idles high out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_meta <= 1'b1;
      s_sync <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= piso_in;
      s_sync <= s_meta;
      s_prev <= s_sync;
    end
  end

  // Frame-level state register, bit timing counters and data shifter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      clk_cnt     <= cnt_clr ? '0 : clk_cnt + CLK_W'(1);
      frame_error <= frame_err_set;
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (shift_en) begin
        shift_reg <= {s_sync, shift_reg[WIDTH-1:1]};
      end
    end
  end

  // Next-state logic: center-samples each bit, sampling the start bit half
  // a bit in and every later bit one full bit-time after the previous one.
  always_comb begin
    state_next    = state;
    cnt_clr       = 1'b0;
    shift_en      = 1'b0;
    bit_clr       = 1'b0;
    push_req      = 1'b0;
    frame_err_set = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (s_prev && !s_sync) begin
          bit_clr    = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (clk_cnt == CLK_W'(HALF - 1)) begin
          cnt_clr    = 1'b1;
          state_next = s_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt == CLK_W'(CLKS_PER_BIT - 1)) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == BIT_W'(WIDTH - 1)) begin
            state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (clk_cnt == CLK_W'(CLKS_PER_BIT - 1)) begin
          cnt_clr = 1'b1;
          if (s_sync) begin
            push_req   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_next    = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_clr = 1'b1;
        if (s_sync) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        cnt_clr    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rx_busy    = (state != ST_IDLE);
  assign fifo_full  = (occ == OCC_W'(OUT_DEPTH));
  assign fifo_empty = (occ == '0);
  assign pop        = packet_valid && packet_ready;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign push_word  = {~(^shift_reg), shift_reg};
  assign head_word  = mem[rd_ptr];

  assign packet_valid = !fifo_empty;
  assign packet_out   = fifo_empty ? '0 : head_word[WIDTH-1:0];
  assign parity_error = fifo_empty ? 1'b0 : head_word[WIDTH];

  // FIFO storage, pointers and occupancy; a push into a full FIFO is only
  // taken when the head is leaving in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Saturating count of packets lost because the FIFO had no room.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != {CNT_W{1'b1}})) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_larpix_piso_packet_rx.sv
// Randomized self-checking bench for larpix_piso_packet_rx with a
// transaction-level queue model of the receive FIFO.
module tb_larpix_piso_packet_rx;

  localparam int C  = 4;
  localparam int W  = 64;
  localparam int D  = 4;
  localparam int CW = 16;
  // Cycles from driving the start bit to the stop-bit sample cycle:
  // two synchronizer stages, half a bit, then 65 full bits.
  localparam int STOP_OFS = 2 + C / 2 + (W + 1) * C;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          piso_in = 1'b1;
  logic          packet_ready = 1'b0;
  logic [W-1:0]  packet_out;
  logic          parity_error;
  logic          packet_valid;
  logic          frame_error;
  logic [CW-1:0] drop_count;
  logic          rx_busy;

  larpix_piso_packet_rx #(
    .CLKS_PER_BIT(C),
    .WIDTH(W),
    .OUT_DEPTH(D),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .piso_in(piso_in),
    .packet_out(packet_out),
    .parity_error(parity_error),
    .packet_valid(packet_valid),
    .packet_ready(packet_ready),
    .frame_error(frame_error),
    .drop_count(drop_count),
    .rx_busy(rx_busy)
  );

  typedef struct {
    int           due;
    logic [W-1:0] data;
    bit           good;
  } frame_t;

  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           last_start = 0;
  int           exp_drops = 0;
  int           ferr_cyc = -1;
  bit           rand_ready = 1'b0;
  frame_t       pending[$];
  logic [W:0]   exp_q[$];
  logic [W-1:0] saved[6];

  // Free-running clock and cycle counter used to time expected events.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // A packet with an even number of ones fails odd parity.
  function automatic logic [W:0] modelEntry(input logic [W-1:0] d);
    logic bad;
    bad = ($countones(d) % 2) == 0;
    return {bad, d};
  endfunction

  task automatic doReset();
    reset = 1'b1;
    piso_in = 1'b1;
    exp_q.delete();
    pending.delete();
    exp_drops = 0;
    ferr_cyc = -1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one frame; optionally raises ready for exactly the stop-sample
  // cycle, or aborts with a reset at the start of a given frame bit.
  task automatic applyStimulus(input logic [W-1:0] data, input bit stop, input bit pulse, input int abort_bit);
    logic [W+1:0] frame;
    int           total;
    int           due;
    frame = {stop, data, 1'b0};
    total = (W + 2) * C + (pulse ? 2 : 0);
    due = 0;
    for (int j = 0; j < total; j++) begin
      @(negedge clk);
      if (j == 0) begin
        last_start = cyc;
        due = cyc + STOP_OFS;
        pending.push_back('{due, data, stop});
      end
      if (abort_bit >= 0 && j == abort_bit * C) begin
        doReset();
        return;
      end
      if (j < (W + 2) * C) piso_in = frame[j / C];
      if (pulse) packet_ready = (cyc == due);
    end
  endtask

  task automatic waitPacket(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput(tag, 64'd0, 64'd1);
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    packet_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    packet_ready = 1'b0;
    if (!done) checkOutput(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic drainOrdered(input string tag, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput(tag, packet_out, saved[first + k]);
      packet_ready = 1'b1;
    end
    @(negedge clk);
    packet_ready = 1'b0;
    checkOutput({tag, "_empty"}, packet_valid, 1'b0);
  endtask

  // Reference model: compares outputs every cycle, then retires handshakes
  // and applies frames whose stop bit is sampled in this cycle.
  initial begin : monitor
    bit exp_valid;
    bit hs;
    forever begin
      @(negedge clk);
      #3;
      exp_valid = exp_q.size() != 0;
      checkOutput("packet_valid", packet_valid, exp_valid);
      if (exp_valid) begin
        checkOutput("packet_out", packet_out, exp_q[0][W-1:0]);
        checkOutput("parity_error", parity_error, exp_q[0][W]);
      end
      checkOutput("drop_count", drop_count, 64'(exp_drops));
      checkOutput("frame_error", frame_error, cyc == ferr_cyc);
      if (!reset) begin
        hs = exp_valid && packet_ready;
        if (hs) void'(exp_q.pop_front());
        if (pending.size() != 0 && pending[0].due == cyc) begin
          if (pending[0].good) begin
            if (exp_q.size() == D) exp_drops++;
            else exp_q.push_back(modelEntry(pending[0].data));
          end else begin
            ferr_cyc = cyc + 1;
          end
          void'(pending.pop_front());
        end
      end
    end
  end

  // Random consumer back-pressure during the soak phase.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) packet_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized soak.
  initial begin
    int  lat;
    int  gap;
    bit  good;
    logic [W-1:0] d;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", packet_valid, 1'b0);
    checkOutput("rst_out", packet_out, 64'd0);
    checkOutput("rst_perr", parity_error, 1'b0);
    checkOutput("rst_ferr", frame_error, 1'b0);
    checkOutput("rst_drop", drop_count, 64'd0);
    checkOutput("rst_busy", rx_busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] single frame");
    applyStimulus(64'h8000_0000_0000_0001, 1'b1, 1'b0, -1);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (packet_valid) begin
        lat = cyc - last_start;
        break;
      end
    end
    checkOutput("latency", 64'(lat), 64'(STOP_OFS + 1));
    checkOutput("t1_data", packet_out, 64'h8000_0000_0000_0001);
    // Two set bits: even population, so the flag is raised.
    checkOutput("t1_perr", parity_error, 1'b1);
    packet_ready = 1'b1;
    @(negedge clk);
    packet_ready = 1'b0;
    checkOutput("t1_pop", packet_valid, 1'b0);

    applyStimulus(64'h8000_0000_0000_0000, 1'b1, 1'b0, -1);
    waitPacket("wait_odd");
    checkOutput("odd_perr", parity_error, 1'b0);
    drain("drain_odd");

    $display("[TB] parity fault");
    applyStimulus(64'h0000_0000_0000_0003, 1'b1, 1'b0, -1);
    waitPacket("wait_par");
    checkOutput("par_data", packet_out, 64'h3);
    checkOutput("par_perr", parity_error, 1'b1);
    checkOutput("par_ferr", frame_error, 1'b0);
    drain("drain_par");

    $display("[TB] framing fault");
    applyStimulus({$urandom, $urandom}, 1'b0, 1'b0, -1);
    repeat (20 * C) @(negedge clk);
    checkOutput("brk_busy", rx_busy, 1'b1);
    checkOutput("brk_nopush", packet_valid, 1'b0);
    piso_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rx_busy) break;
    end
    checkOutput("brk_release", rx_busy, 1'b0);
    applyStimulus({$urandom, $urandom}, 1'b1, 1'b0, -1);
    waitPacket("wait_after_brk");
    drain("drain_brk");

    $display("[TB] overflow");
    for (int k = 0; k < 6; k++) begin
      saved[k] = {$urandom, $urandom};
      applyStimulus(saved[k], 1'b1, 1'b0, -1);
    end
    repeat (3) @(negedge clk);
    checkOutput("ovf_drop", drop_count, 64'd2);
    checkOutput("ovf_valid", packet_valid, 1'b1);
    drainOrdered("ovf_order", 0, 4);

    $display("[TB] glitch and reset");
    @(negedge clk);
    piso_in = 1'b0;
    @(negedge clk);
    piso_in = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitch_valid", packet_valid, 1'b0);
    checkOutput("glitch_busy", rx_busy, 1'b0);
    applyStimulus({$urandom, $urandom}, 1'b1, 1'b0, 31);
    checkOutput("abort_drop", drop_count, 64'd0);
    checkOutput("abort_busy", rx_busy, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus({$urandom, $urandom}, 1'b1, 1'b0, -1);
    waitPacket("wait_after_rst");
    drain("drain_rst");

    $display("[TB] push and pop while full");
    for (int k = 0; k < 5; k++) begin
      saved[k] = {$urandom, $urandom};
      applyStimulus(saved[k], 1'b1, k == 4, -1);
    end
    repeat (3) @(negedge clk);
    checkOutput("full_drop", drop_count, 64'd0);
    drainOrdered("full_order", 1, 4);

    $display("[TB] random soak");
    rand_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      d = {$urandom, $urandom};
      good = ($urandom_range(0, 7) != 0);
      applyStimulus(d, good, 1'b0, -1);
      gap = good ? $urandom_range(0, 3) : $urandom_range(2, 4);
      for (int g = 0; g < gap * C; g++) begin
        @(negedge clk);
        piso_in = 1'b1;
      end
    end
    repeat (10) @(negedge clk);
    rand_ready = 1'b0;
    @(negedge clk);
    drain("drain_soak");
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
